mul_issue_ctrl: RTL and testbench



---
 rtl/mul_pkg.sv | 7 +
 rtl/op_fifo.sv | 41 ++++
 rtl/mul_issue_ctrl.sv | 101 ++++++++++
 tb/tb_mul_issue_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared widths and FSM state encoding for the multiplier issue controller.
package mul_pkg;
    localparam int OP_W        = 8;
    localparam int PROD_W      = 16;
    localparam int MULT_PROD_W = 17;
    typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, RESP} state_t;
endpackage

// File: rtl/op_fifo.sv
// op_fifo: power-of-two operand FIFO with separate occupancy count and synchronous reset.
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push, w_pop;
    assign full   = r_cnt == CNT_FULL;
    assign empty  = r_cnt == '0;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign head   = r_mem[r_rd];
    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end
endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: buffers operand pairs and sequences them through a shift-add multiplier.
// Optional watchdog on the multiplier handshake is enabled by defining MUL_TIMEOUT_EN.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_a,
    input  logic [OP_W-1:0]        in_b,
    output logic                   mul_reset,
    output logic                   mul_start,
    output logic [OP_W-1:0]        mul_multiplicand,
    output logic [OP_W-1:0]        mul_multiplier,
    input  logic [MULT_PROD_W-1:0] mul_product,
    input  logic                   mul_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PROD_W-1:0]      out_product,
    output logic                   out_err
);
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1)
        $error("mul_issue_ctrl: DEPTH must be a power of two in 2..16 and TIMEOUT >= 1");

    state_t              r_state, w_next;
    logic                w_full, w_empty, w_cap, w_tmo, w_pop;
    logic [2*OP_W-1:0]   w_head;
    logic                r_mul_reset, r_mul_start, r_out_valid;
    logic [PROD_W-1:0]   r_out_product;
    logic                w_unused_msb;

    op_fifo #(.DEPTH(DEPTH), .W(2*OP_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (w_pop),
        .din   ({in_a, in_b}),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign in_ready         = !reset && !w_full;
    assign mul_multiplicand = w_head[2*OP_W-1:OP_W];
    assign mul_multiplier   = w_head[OP_W-1:0];
    assign mul_reset        = r_mul_reset;
    assign mul_start        = r_mul_start;
    assign out_valid        = r_out_valid;
    assign out_product      = r_out_product;
    assign w_unused_msb     = mul_product[PROD_W];

    // A done seen outside ISSUE is stale; CLEAR always re-arms the multiplier first.
    assign w_cap = r_state == ISSUE && mul_done;
    assign w_pop = w_cap || w_tmo;

`ifdef MUL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_tcnt;
    logic          r_out_err;
    always_ff @(posedge clk) begin
        r_tcnt <= (reset || r_state != ISSUE) ? '0 : r_tcnt + 1'b1;
    end
    assign w_tmo = r_state == ISSUE && !mul_done && r_tcnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (reset) r_out_err <= 1'b0;
        else if (w_pop) r_out_err <= w_tmo;
    end
    assign out_err = r_out_err;
`else
    assign w_tmo   = 1'b0;
    assign out_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state == IDLE  ? (w_empty ? IDLE : CLEAR)
               : r_state == CLEAR ? ISSUE
               : r_state == ISSUE ? (w_pop ? RESP : ISSUE)
               : (out_ready ? IDLE : RESP);
    end

    // Handshake outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_mul_reset   <= 1'b1;
            r_mul_start   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
        end else begin
            r_state     <= w_next;
            r_mul_reset <= w_next == CLEAR;
            r_mul_start <= w_next == ISSUE;
            r_out_valid <= w_next == RESP;
            if (w_pop) r_out_product <= w_cap ? mul_product[PROD_W-1:0] : '0;
        end
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: scoreboard bench with a behavioural shift-add multiplier model.
module tb_mul_issue_ctrl;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 0, reset = 1, in_valid = 0, out_ready = 1;
    logic [7:0]  in_a = 0, in_b = 0;
    logic        in_ready, mul_reset, mul_start, mul_done, out_valid, out_err;
    logic [7:0]  mul_multiplicand, mul_multiplier;
    logic [16:0] mul_product;
    logic [15:0] out_product;
    int          n_vec = 0, n_bad = 0, pulses = 0, start_cycles = 0;
    logic        mr_prev = 0, tie_done_low = 0;
    logic [16:0] exp_q [$];

    mul_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .mul_reset        (mul_reset),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_done         (mul_done),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .out_err          (out_err)
    );

    always #5 clk = ~clk;

    // Multiplier model: loads on reset, runs ~19 cycles after start, then holds done until reset.
    logic [4:0]  m_cnt = 0;
    logic        m_busy = 0, m_done = 0;
    logic [16:0] m_prod = 0;
    always_ff @(posedge clk) begin
        if (mul_reset) begin
            m_cnt <= 0; m_busy <= 0; m_done <= 0; m_prod <= 0;
        end else if (!m_busy && !m_done && mul_start) begin
            m_busy <= 1; m_cnt <= 0;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 17) begin
                m_busy <= 0; m_done <= 1;
                m_prod <= {1'b1, 16'(mul_multiplicand) * 16'(mul_multiplier)};
            end
        end
    end
    assign mul_done    = m_done && !tie_done_low;
    assign mul_product = m_prod;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && mul_reset && !mr_prev) pulses++;
        mr_prev = mul_reset;
        if (mul_start) start_cycles++;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", {15'd0, out_err, out_product}, 32'h1ffff);
            else chk("product", {15'd0, out_err, out_product}, {15'd0, exp_q.pop_front()});
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p, input logic e);
        int t = 0;
        in_valid = 1; in_a = a; in_b = b;
        while (!in_ready && t < 500) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) chk("push_timeout", 0, 1);
        else exp_q.push_back({e, p});
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk); t++;
        end
        chk(name, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, s0, t;
        logic bad_hold, bad_start;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mul_reset", mul_reset, 1);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_product", out_product, 0);
        chk("rst_out_err", out_err, 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(negedge clk);
        chk("post_rst_mul_reset", mul_reset, 0);
        @(posedge clk); #1;

        p0 = pulses;
        push(255, 250, 16'd63750, 0);
        drain("single_drain");
        chk("single_pulses", pulses - p0, 1);

        p0 = pulses;
        push(14, 13, 16'd182, 0);
        push(24, 34, 16'd816, 0);
        push(76, 98, 16'd7448, 0);
        drain("b2b_drain");
        chk("b2b_pulses", pulses - p0, 3);

        out_ready = 0;
        push(101, 102, 16'd10302, 0);
        t = 0;
        while (!out_valid && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("bp_valid", out_valid, 1);
        push(10, 10, 16'd100, 0);
        bad_hold = 0; bad_start = 0;
        repeat (50) begin
            @(negedge clk);
            if (!out_valid || out_product !== 16'd10302) bad_hold = 1;
            if (mul_start) bad_start = 1;
        end
        chk("bp_hold", bad_hold, 0);
        chk("bp_no_start", bad_start, 0);
        @(posedge clk); #1;
        out_ready = 1;
        drain("bp_drain");

        out_ready = 0;
        push(1, 1, 16'd1, 0);
        push(2, 3, 16'd6, 0);
        push(17, 19, 16'd323, 0);
        push(200, 7, 16'd1400, 0);
        chk("full_in_ready", in_ready, 0);
        fork
            begin
                push(128, 128, 16'd16384, 0);
                push(0, 99, 16'd0, 0);
            end
            begin
                repeat (80) @(posedge clk);
                #1;
                chk("full_stall_in_ready", in_ready, 0);
                out_ready = 1;
            end
        join
        drain("full_drain");

        push(255, 255, 16'd65025, 0);
        t = 0;
        while (!mul_start && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("midop_issue", mul_start, 1);
        @(posedge clk); #1;
        reset = 1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midop_mul_reset", mul_reset, 1);
        chk("midop_out_valid", out_valid, 0);
        chk("midop_in_ready", in_ready, 0);
        chk("midop_mul_start", mul_start, 0);
        @(posedge clk); #1;
        reset = 0;
        p0 = pulses;
        repeat (10) @(negedge clk);
        chk("midop_flushed", pulses - p0, 0);
        @(posedge clk); #1;
        push(3, 5, 16'd15, 0);
        drain("midop_drain");

`ifdef MUL_TIMEOUT_EN
        tie_done_low = 1;
        s0 = start_cycles;
        push(9, 9, 16'd0, 1);
        drain("tmo_drain");
        chk("tmo_issue_cycles", start_cycles - s0, TIMEOUT);
        tie_done_low = 0;
        push(6, 7, 16'd42, 0);
        drain("tmo_recover_drain");
`else
        s0 = start_cycles;
        push(6, 7, 16'd42, 0);
        drain("final_drain");
        chk("final_err", out_err, 0);
`endif
        chk("issue_cycles_seen", (start_cycles - s0) > 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end
endmodule
